// File: rtl/avalon_ram_param.sv
// avalon_ram_param: Avalon-MM slave RAM with four relocatable byte regions.
//
// Storage is 4*REGION_BYTES bytes. Region i answers byte addresses in
// [REGION_BASEi, REGION_BASEi+REGION_BYTES) and maps onto storage slice i.
// Every transfer takes WAIT_CYCLES+2 cycles: the request cycle (IDLE),
// WAIT_CYCLES wait states (WAIT) and one completion cycle (ACK) with
// waitrequest low. Accesses that miss every region still complete with normal
// timing; they return zero and set the sticky unmapped_err flag.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   address        byte address (bits [1:0] ignored for the storage index)
//   read, write    request strobes; both high is treated as a read + error
//   writedata      write data, lane k = writedata[8k+7:8k]
//   byteenable     lane k enables byte k of a write
//   waitrequest    low for exactly the completion cycle of a transfer
//   readdata       read word, registered on completion, held until next read
//   unmapped_err   sticky error flag, cleared only by reset
module avalon_ram_param #(
  parameter int unsigned REGION_BYTES = 2048,
  parameter logic [31:0] REGION_BASE0 = 32'h0000_0000,
  parameter logic [31:0] REGION_BASE1 = 32'h8000_0000,
  parameter logic [31:0] REGION_BASE2 = 32'hBFC0_0000,
  parameter logic [31:0] REGION_BASE3 = 32'hFFFF_F800,
  parameter int unsigned WAIT_CYCLES  = 1,
  parameter string       RAM_FILE     = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        unmapped_err
);

  localparam int unsigned MEM_BYTES = 4 * REGION_BYTES;
  localparam int unsigned OFF_W     = $clog2(REGION_BYTES);
  localparam int unsigned IDX_W     = OFF_W + 2;
  localparam int unsigned CNT_W     = 4;

  localparam logic [CNT_W-1:0] WAIT_INIT   = CNT_W'(WAIT_CYCLES);
  localparam logic [31:0]      REGION_SPAN = 32'(REGION_BYTES);
  localparam logic [31:0]      BASE [4]    = '{REGION_BASE0, REGION_BASE1,
                                               REGION_BASE2, REGION_BASE3};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q;
  logic               rd_q;
  logic               wr_q;
  logic               both_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               waitreq_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic               accept_c;
  logic               go_ack_c;
  logic [31:0]        cur_addr_c;
  logic               cur_rd_c;
  logic               cur_wr_c;
  logic               cur_both_c;
  logic [31:0]        cur_wdata_c;
  logic [3:0]         cur_be_c;
  logic [31:0]        diff_c;
  logic               hit_c;
  logic [1:0]         sel_c;
  logic [OFF_W-1:0]   off_c;
  logic [IDX_W-1:0]   idx_c;
  logic [31:0]        rd_word_c;

  logic [7:0]         mem_q [MEM_BYTES];

  // Power-up image: zero fill.
  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) mem_q[i] = 8'h00;
  end

  // Operation being serviced: live inputs in IDLE (needed when WAIT_CYCLES=0
  // completes on the accepting edge), latched copy afterwards.
  always_comb begin
    cur_addr_c  = addr_q;
    cur_rd_c    = rd_q;
    cur_wr_c    = wr_q;
    cur_both_c  = both_q;
    cur_wdata_c = wdata_q;
    cur_be_c    = be_q;
    if (state_q == IDLE) begin
      cur_addr_c  = address;
      cur_rd_c    = read;
      cur_wr_c    = write & ~read;
      cur_both_c  = read & write;
      cur_wdata_c = writedata;
      cur_be_c    = byteenable;
    end
  end

  // Region decode; scanning downwards lets the lowest matching index win.
  // Unsigned subtraction also covers a region that ends exactly at 2^32.
  always_comb begin
    hit_c  = 1'b0;
    sel_c  = 2'd0;
    off_c  = '0;
    diff_c = '0;
    for (int i = 3; i >= 0; i--) begin
      diff_c = cur_addr_c - BASE[i];
      if (diff_c < REGION_SPAN) begin
        hit_c = 1'b1;
        sel_c = 2'(i);
        off_c = diff_c[OFF_W-1:0];
      end
    end
    // Word-aligned index keeps all four lanes inside one region.
    idx_c = {sel_c, off_c} & ~IDX_W'(3);
  end

  // Little-endian word view of the addressed storage.
  always_comb begin
    rd_word_c = '0;
    for (int k = 0; k < 4; k++) begin
      rd_word_c[8*k +: 8] = mem_q[idx_c + IDX_W'(k)];
    end
  end

  // Next-state logic for the IDLE -> WAIT -> ACK handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    go_ack_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read | write) begin
          accept_c = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = ACK;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // ACK never persists, so entering it is simply a next state of ACK.
    go_ack_c = (state_d == ACK);
  end

  // Control, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      both_q    <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      waitreq_q <= 1'b1;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      waitreq_q <= ~go_ack_c;
      if (accept_c) begin
        addr_q  <= address;
        rd_q    <= read;
        wr_q    <= write & ~read;
        both_q  <= read & write;
        wdata_q <= writedata;
        be_q    <= byteenable;
      end
      if (go_ack_c) begin
        if (cur_rd_c) rdata_q <= hit_c ? rd_word_c : 32'h0000_0000;
        if (!hit_c || cur_both_c) err_q <= 1'b1;
      end
    end
  end

  // Byte-lane writes land on the edge entering ACK; storage has no reset.
  always_ff @(posedge clk) begin
    if (go_ack_c && cur_wr_c && hit_c) begin
      for (int k = 0; k < 4; k++) begin
        if (cur_be_c[k]) mem_q[idx_c + IDX_W'(k)] <= cur_wdata_c[8*k +: 8];
      end
    end
  end

  assign waitrequest  = waitreq_q;
  assign readdata     = rdata_q;
  assign unmapped_err = err_q;

endmodule

// File: tb/tb_avalon_ram_param.sv
// Bench for avalon_ram_param: three instances (1, 3 and 0 wait states, the
// last with 64-byte regions). Drivers push the expected completion into a
// queue; a negedge monitor pops it when waitrequest drops and checks latency,
// readdata and unmapped_err.
module tb_avalon_ram_param;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst_n        [NDUT];
  logic [31:0] address      [NDUT];
  logic        read         [NDUT];
  logic        write        [NDUT];
  logic [31:0] writedata    [NDUT];
  logic [3:0]  byteenable   [NDUT];
  logic        waitrequest  [NDUT];
  logic [31:0] readdata     [NDUT];
  logic        unmapped_err [NDUT];

  always #5 clk = ~clk;

  avalon_ram_param #(.WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .address(address[0]), .read(read[0]),
    .write(write[0]), .writedata(writedata[0]), .byteenable(byteenable[0]),
    .waitrequest(waitrequest[0]), .readdata(readdata[0]),
    .unmapped_err(unmapped_err[0]));

  avalon_ram_param #(.WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .address(address[1]), .read(read[1]),
    .write(write[1]), .writedata(writedata[1]), .byteenable(byteenable[1]),
    .waitrequest(waitrequest[1]), .readdata(readdata[1]),
    .unmapped_err(unmapped_err[1]));

  avalon_ram_param #(.REGION_BYTES(64), .WAIT_CYCLES(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .address(address[2]), .read(read[2]),
    .write(write[2]), .writedata(writedata[2]), .byteenable(byteenable[2]),
    .waitrequest(waitrequest[2]), .readdata(readdata[2]),
    .unmapped_err(unmapped_err[2]));

  typedef struct {
    int          d;
    bit          chk_rd;
    logic [31:0] rd;
    bit          err;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 3;
      1:       return 5;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one completion per popped expectation.
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rst_n[d] === 1'b1 && waitrequest[d] === 1'b0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion dut%0d: got completion expected none", d);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk($sformatf("dut_id_dut%0d", d), 32'(d), 32'(e.d));
          chk($sformatf("latency_dut%0d", d), 32'(cyc - e.start + 1), 32'(e.lat));
          if (e.chk_rd) chk($sformatf("readdata_dut%0d", d), readdata[d], e.rd);
          chk($sformatf("unmapped_err_dut%0d", d), 32'(unmapped_err[d]), 32'(e.err));
        end
      end
    end
  end

  // One Avalon transfer; scramble perturbs the inputs once the request has
  // been accepted, which the DUT must ignore.
  task automatic xfer(input int d, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] exp_rd, input bit exp_err, input bit scramble);
    exp_t e;
    bit   done;
    @(posedge clk);
    #1;
    address[d]    = a;
    read[d]       = rd;
    write[d]      = wr;
    writedata[d]  = wd;
    byteenable[d] = be;
    e.d      = d;
    e.chk_rd = rd;
    e.rd     = exp_rd;
    e.err    = exp_err;
    e.lat    = lat_of(d);
    e.start  = cyc;
    sb_q.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (waitrequest[d] === 1'b0) begin
        done = 1'b1;
      end else if (scramble && i == 1) begin
        address[d]    = a ^ 32'h0000_0100;
        writedata[d]  = ~wd;
        byteenable[d] = 4'h0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout_dut%0d: got no completion expected one within 40 cycles", d);
    end
    @(posedge clk);
    #1;
    read[d]  = 1'b0;
    write[d] = 1'b0;
  endtask

  task automatic wr_op(input int d, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input bit exp_err);
    xfer(d, 1'b0, 1'b1, a, wd, be, 32'h0, exp_err, 1'b0);
  endtask

  task automatic rd_op(input int d, input logic [31:0] a, input logic [31:0] exp_rd,
                       input bit exp_err);
    xfer(d, 1'b1, 1'b0, a, 32'h0, 4'h0, exp_rd, exp_err, 1'b0);
  endtask

  task automatic reset_pulse(input int d);
    @(negedge clk);
    #2;
    rst_n[d] = 1'b0;
    #1;
    chk($sformatf("rst_waitrequest_dut%0d", d), 32'(waitrequest[d]), 32'd1);
    chk($sformatf("rst_readdata_dut%0d", d), readdata[d], 32'h0);
    chk($sformatf("rst_unmapped_err_dut%0d", d), 32'(unmapped_err[d]), 32'd0);
    @(negedge clk);
    rst_n[d] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected end before 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst_n[d]      = 1'b1;
      address[d]    = '0;
      read[d]       = 1'b0;
      write[d]      = 1'b0;
      writedata[d]  = '0;
      byteenable[d] = '0;
    end
    // Reset takes effect before any clock edge.
    #2;
    for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("por_waitrequest_dut%0d", d), 32'(waitrequest[d]), 32'd1);
      chk($sformatf("por_readdata_dut%0d", d), readdata[d], 32'h0);
      chk($sformatf("por_unmapped_err_dut%0d", d), 32'(unmapped_err[d]), 32'd0);
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;

    // dut0: one wait state, default map.
    wr_op(0, 32'h8000_0010, 32'hCAFE_F00D, 4'hF, 1'b0);
    rd_op(0, 32'h8000_0010, 32'hCAFE_F00D, 1'b0);
    wr_op(0, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0);
    wr_op(0, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 1'b0);
    rd_op(0, 32'h0000_0020, 32'h11BB_33DD, 1'b0);
    wr_op(0, 32'hBFC0_07FC, 32'h0102_0304, 4'hF, 1'b0);
    rd_op(0, 32'hBFC0_07FC, 32'h0102_0304, 1'b0);
    rd_op(0, 32'h0000_07FC, 32'h0000_0000, 1'b0);
    rd_op(0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
    rd_op(0, 32'h8000_0010, 32'hCAFE_F00D, 1'b0);
    wr_op(0, 32'h0000_0024, 32'h1234_5678, 4'hF, 1'b0);
    chk("readdata_hold_dut0", readdata[0], 32'hCAFE_F00D);
    rd_op(0, 32'hBFC0_0800, 32'h0000_0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky_dut0", 32'(unmapped_err[0]), 32'd1);
    reset_pulse(0);
    rd_op(0, 32'hBFC0_07FC, 32'h0102_0304, 1'b0);
    wr_op(0, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd_op(0, 32'h8000_0010, 32'hCAFE_F00D, 1'b1);
    rd_op(0, 32'h0000_0020, 32'h11BB_33DD, 1'b1);
    rd_op(0, 32'h0000_0024, 32'h1234_5678, 1'b1);
    rd_op(0, 32'h0000_0000, 32'h0000_0000, 1'b1);
    reset_pulse(0);
    // read and write together: a read that flags the error, no write.
    xfer(0, 1'b1, 1'b1, 32'h8000_0010, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 1'b1, 1'b0);
    rd_op(0, 32'h8000_0010, 32'hCAFE_F00D, 1'b1);

    // dut1: three wait states, reset in the middle of a write.
    wr_op(1, 32'h8000_0100, 32'h1234_5678, 4'hF, 1'b0);
    rd_op(1, 32'h8000_0100, 32'h1234_5678, 1'b0);
    @(posedge clk);
    #1;
    address[1]    = 32'h8000_0100;
    write[1]      = 1'b1;
    writedata[1]  = 32'hDEAD_BEEF;
    byteenable[1] = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n[1] = 1'b0;
    #1;
    chk("midwrite_waitrequest_dut1", 32'(waitrequest[1]), 32'd1);
    chk("midwrite_readdata_dut1", readdata[1], 32'h0);
    chk("midwrite_unmapped_err_dut1", 32'(unmapped_err[1]), 32'd0);
    write[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1;
    rd_op(1, 32'h8000_0100, 32'h1234_5678, 1'b0);
    xfer(1, 1'b0, 1'b1, 32'h8000_0200, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 1'b1);
    xfer(1, 1'b1, 1'b0, 32'h8000_0200, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, 1'b1);
    rd_op(1, 32'h8000_0300, 32'h0000_0000, 1'b0);

    // dut2: zero wait states, 64-byte regions.
    wr_op(2, 32'h0000_0010, 32'h0BAD_F00D, 4'hF, 1'b0);
    rd_op(2, 32'h0000_0010, 32'h0BAD_F00D, 1'b0);
    rd_op(2, 32'h0000_0014, 32'h0000_0000, 1'b0);
    wr_op(2, 32'h0000_003C, 32'h0102_0304, 4'b1000, 1'b0);
    rd_op(2, 32'h0000_003C, 32'h0100_0000, 1'b0);
    rd_op(2, 32'hFFFF_F83C, 32'h0000_0000, 1'b0);
    rd_op(2, 32'h0000_0040, 32'h0000_0000, 1'b1);
    rd_op(2, 32'h0000_0010, 32'h0BAD_F00D, 1'b1);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
